pmp_csr_regfile: RTL and testbench

- Writer side of the PMP configuration consumed by the fetch/LSU PMP checkers.
- Owns the pmpcfg/pmpaddr architectural state and applies the WARL and lock rules on CSR accesses from the CSR file.
- Drives the packed pmpcfg/pmpaddr buses into the checkers, and pulses an update strobe so downstream logic can flush cached permission state.

---
 rtl/pmp_csr_regfile.sv | 166 ++++++++++++++++
 tb/tb_pmp_csr_regfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_csr_regfile.sv
// PMP CSR register file: pmpcfg/pmpaddr state with WARL and lock legalisation,
// a two-state request/response handshake, and packed outputs for the PMP checkers.

package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned PLEN;
    int unsigned NrPMPEntries;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, PLEN: 56, NrPMPEntries: 16};
endpackage

package riscv;
  typedef enum logic [1:0] {OFF = 2'b00, TOR = 2'b01, NA4 = 2'b10, NAPOT = 2'b11} pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;
endpackage

module pmp_csr_regfile #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned GRAIN = 0,
  localparam int XLEN  = int'(CVA6Cfg.XLEN),
  localparam int PLEN  = int'(CVA6Cfg.PLEN),
  localparam int NR    = int'(CVA6Cfg.NrPMPEntries),
  localparam int NRREG = (NR == 0) ? 1 : NR
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             csr_req_i,
  output logic                             csr_ready_o,
  input  logic                             csr_we_i,
  input  logic [11:0]                      csr_addr_i,
  input  logic [XLEN-1:0]                  csr_wdata_i,
  output logic                             csr_rvalid_o,
  output logic [XLEN-1:0]                  csr_rdata_o,
  output logic                             csr_err_o,
  output logic                             cfg_update_o,
  output riscv::pmpcfg_t [NRREG-1:0]       pmpcfg_o,
  output logic [NRREG-1:0][PLEN-3:0]       pmpaddr_o
);

  localparam int CfgPerReg = XLEN / 8;
  localparam logic [PLEN-3:0] NapotMask =
    (GRAIN >= 2) ? (PLEN-2)'((64'd1 << (GRAIN - 1)) - 64'd1) : '0;
  localparam logic [PLEN-3:0] OffMask =
    (GRAIN >= 1) ? (PLEN-2)'((64'd1 << GRAIN) - 64'd1) : '0;

  typedef enum logic {IDLE, RESP} state_e;

  state_e                   state_q, state_d;
  logic [NRREG-1:0][7:0]    cfg_q, cfg_d;
  logic [NRREG-1:0][PLEN-3:0] addr_q, addr_d;
  logic [XLEN-1:0]          rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     update_q, changed;
  logic                     accept, is_cfg, is_addr;
  logic [5:0]               addr_k;
  int                       cfg_grp;
  logic [NRREG-1:0]         lock_tor, tor_lock_above;
  logic [7:0]               wbyte;

  function automatic logic cfg_byte_legal(input logic [7:0] old_b, input logic [7:0] new_b);
    return !old_b[7] && !(new_b[1] && !new_b[0]) && !(GRAIN >= 1 && new_b[4:3] == 2'b10);
  endfunction

  function automatic logic [PLEN-3:0] addr_view(input logic [PLEN-3:0] a, input logic [1:0] mode);
    logic [PLEN-3:0] v;
    v = a;
    if (mode == 2'b11) v = v | NapotMask;
    if (!mode[1])      v = v & ~OffMask;
    return v;
  endfunction

  assign accept  = csr_req_i && (state_q == IDLE);
  assign is_cfg  = (csr_addr_i[11:4] == 8'h3A) && (XLEN == 32 || !csr_addr_i[0]);
  assign is_addr = (csr_addr_i >= 12'h3B0) && (csr_addr_i <= 12'h3EF);
  assign addr_k  = 6'(csr_addr_i - 12'h3B0);
  assign cfg_grp = (int'(csr_addr_i[3:0]) * 4) / CfgPerReg;

  // Entry K+1 locked in TOR mode freezes the base address held in pmpaddr K.
  always_comb begin
    for (int e = 0; e < NRREG; e++) begin
      lock_tor[e] = cfg_q[e][7] && (cfg_q[e][4:3] == 2'b01);
    end
    tor_lock_above = lock_tor >> 1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All legality decisions look at the pre-write state so a write that locks cannot gate itself.
  always_comb begin
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    rdata_d = '0;
    err_d   = 1'b0;
    wbyte   = '0;
    if (accept) begin
      if (is_cfg) begin
        for (int e = 0; e < NRREG; e++) begin
          if (e < NR && (e / CfgPerReg) == cfg_grp) begin
            wbyte = csr_wdata_i[(e % CfgPerReg)*8 +: 8];
            rdata_d[(e % CfgPerReg)*8 +: 8] = cfg_q[e];
            if (csr_we_i && cfg_byte_legal(cfg_q[e], wbyte)) cfg_d[e] = wbyte & 8'h9F;
          end
        end
      end else if (is_addr) begin
        for (int e = 0; e < NRREG; e++) begin
          if (e < NR && e == int'(addr_k)) begin
            rdata_d = XLEN'(addr_view(addr_q[e], cfg_q[e][4:3]));
            if (csr_we_i && !cfg_q[e][7] && !tor_lock_above[e]) addr_d[e] = csr_wdata_i[PLEN-3:0];
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign changed = (cfg_d != cfg_q) || (addr_d != addr_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      update_q <= changed;
    end
  end

  assign csr_ready_o  = (state_q == IDLE);
  assign csr_rvalid_o = (state_q == RESP);
  assign csr_rdata_o  = rdata_q;
  assign csr_err_o    = err_q;
  assign cfg_update_o = update_q;
  assign pmpcfg_o     = cfg_q;
  assign pmpaddr_o    = addr_q;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Randomized self-checking bench for pmp_csr_regfile (XLEN=64, 16 entries, GRAIN=2)
// against a behavioural model of the PMP CSR rules.

module tb_pmp_csr_regfile;
  localparam config_pkg::cva6_cfg_t Cfg = '{XLEN: 64, PLEN: 56, NrPMPEntries: 16};
  localparam int NR = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   csr_req_i;
  logic                   csr_ready_o;
  logic                   csr_we_i;
  logic [11:0]            csr_addr_i;
  logic [63:0]            csr_wdata_i;
  logic                   csr_rvalid_o;
  logic [63:0]            csr_rdata_o;
  logic                   csr_err_o;
  logic                   cfg_update_o;
  riscv::pmpcfg_t [NR-1:0] pmpcfg_o;
  logic [NR-1:0][53:0]    pmpaddr_o;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  cfgM  [NR+1];
  logic [53:0] addrM [NR];

  pmp_csr_regfile #(.CVA6Cfg(Cfg), .GRAIN(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_req_i(csr_req_i), .csr_ready_o(csr_ready_o),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o),
    .cfg_update_o(cfg_update_o), .pmpcfg_o(pmpcfg_o), .pmpaddr_o(pmpaddr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic checkState();
    for (int e = 0; e < NR; e++) begin
      checkOutput($sformatf("pmpcfg%0d", e), 64'(pmpcfg_o[e]), 64'(cfgM[e]));
      checkOutput($sformatf("pmpaddr%0d", e), 64'(pmpaddr_o[e]), 64'(addrM[e]));
    end
  endtask

  task automatic modelClear();
    for (int e = 0; e <= NR; e++) cfgM[e] = 8'h00;
    for (int e = 0; e < NR; e++) addrM[e] = '0;
  endtask

  task automatic modelAccess(input logic we, input logic [11:0] addr, input logic [63:0] wd,
                             output logic [63:0] expRdata, output logic expErr, output logic expUpd);
    int n, k, e;
    logic [7:0] b, nb;
    logic [53:0] v;
    expRdata = '0;
    expErr = 1'b0;
    expUpd = 1'b0;
    if (addr >= 12'h3A0 && addr <= 12'h3AF) begin
      n = int'(addr - 12'h3A0);
      if (n % 2 == 1) expErr = 1'b1;
      else begin
        for (int i = 0; i < 8; i++) begin
          e = n * 4 + i;
          if (e < NR) begin
            expRdata[i*8 +: 8] = cfgM[e];
            b = wd[i*8 +: 8];
            if (we && !cfgM[e][7] && !(b[1] && !b[0]) && b[4:3] != 2'b10) begin
              nb = b & 8'h9F;
              if (nb != cfgM[e]) expUpd = 1'b1;
              cfgM[e] = nb;
            end
          end
        end
      end
    end else if (addr >= 12'h3B0 && addr <= 12'h3EF) begin
      k = int'(addr - 12'h3B0);
      if (k < NR) begin
        v = addrM[k];
        if (cfgM[k][4:3] == 2'b11) v[0] = 1'b1;
        if (cfgM[k][4:3] == 2'b00 || cfgM[k][4:3] == 2'b01) v[1:0] = 2'b00;
        expRdata = {10'b0, v};
        if (we && !cfgM[k][7] && !(cfgM[k+1][7] && cfgM[k+1][4:3] == 2'b01 && k + 1 < NR)) begin
          if (addrM[k] != wd[53:0]) expUpd = 1'b1;
          addrM[k] = wd[53:0];
        end
      end
    end else begin
      expErr = 1'b1;
    end
  endtask

  // One access; returns #1 after the accept edge with the request still asserted.
  task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [63:0] wd);
    logic [63:0] expRdata;
    logic expErr, expUpd;
    int waitCycles;
    @(negedge clk_i);
    csr_req_i = 1'b1;
    csr_we_i = we;
    csr_addr_i = addr;
    csr_wdata_i = wd;
    waitCycles = 0;
    while (!csr_ready_o && waitCycles < 4) begin
      @(posedge clk_i);
      #1;
      checkOutput("rvalid_after_resp", 64'(csr_rvalid_o), 64'd0);
      checkOutput("update_after_resp", 64'(cfg_update_o), 64'd0);
      waitCycles++;
    end
    if (!csr_ready_o) begin
      checkOutput("ready_timeout", 64'(csr_ready_o), 64'd1);
      return;
    end
    modelAccess(we, addr, wd, expRdata, expErr, expUpd);
    @(posedge clk_i);
    #1;
    checkOutput("rvalid", 64'(csr_rvalid_o), 64'd1);
    checkOutput("ready_in_resp", 64'(csr_ready_o), 64'd0);
    checkOutput($sformatf("rdata@%0h", addr), csr_rdata_o, expRdata);
    checkOutput($sformatf("err@%0h", addr), 64'(csr_err_o), 64'(expErr));
    checkOutput($sformatf("update@%0h", addr), 64'(cfg_update_o), 64'(expUpd));
    checkState();
  endtask

  task automatic doReset();
    csr_req_i = 1'b0;
    rst_i = 1'b1;
    modelClear();
    #3;
    checkOutput("rst_ready", 64'(csr_ready_o), 64'd1);
    checkOutput("rst_rvalid", 64'(csr_rvalid_o), 64'd0);
    checkOutput("rst_rdata", csr_rdata_o, 64'd0);
    checkOutput("rst_err", 64'(csr_err_o), 64'd0);
    checkOutput("rst_update", 64'(cfg_update_o), 64'd0);
    checkState();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk_i);
    csr_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("idle_rvalid", 64'(csr_rvalid_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] wd;
    logic [11:0] addr;
    int sel;
    rst_i = 1'b1;
    csr_req_i = 1'b0;
    csr_we_i = 1'b0;
    csr_addr_i = '0;
    csr_wdata_i = '0;
    doReset();

    // Reads after reset, write/readback of pmpcfg0.
    applyStimulus(1'b0, 12'h3A0, 64'd0);
    applyStimulus(1'b0, 12'h3B0, 64'd0);
    applyStimulus(1'b1, 12'h3A0, 64'h0000_0000_0000_0F1B);
    checkOutput("cfg0_1B", 64'(pmpcfg_o[0]), 64'h1B);
    checkOutput("cfg1_0F", 64'(pmpcfg_o[1]), 64'h0F);
    checkOutput("update_F1B", 64'(cfg_update_o), 64'd1);
    applyStimulus(1'b0, 12'h3A0, 64'd0);
    checkOutput("readback_F1B", csr_rdata_o, 64'h0F1B);

    // Locked entry 0 rejects pmpaddr0 and pmpcfg writes.
    applyStimulus(1'b1, 12'h3A0, 64'h0000_0000_0000_0F8D);
    applyStimulus(1'b1, 12'h3B0, 64'h1234);
    checkOutput("locked_addr0", 64'(pmpaddr_o[0]), 64'd0);
    checkOutput("locked_addr0_upd", 64'(cfg_update_o), 64'd0);
    applyStimulus(1'b1, 12'h3A0, 64'h0000_0000_0000_0F00);
    checkOutput("locked_cfg0", 64'(pmpcfg_o[0]), 64'h8D);

    // TOR lock on entry 1 protects pmpaddr0; illegal W-only and NA4 encodings.
    doReset();
    applyStimulus(1'b1, 12'h3A0, 64'h0000_0000_1800_8800);
    applyStimulus(1'b1, 12'h3B0, 64'h55);
    checkOutput("tor_lock_addr0", 64'(pmpaddr_o[0]), 64'd0);
    applyStimulus(1'b1, 12'h3B2, 64'h55);
    checkOutput("addr2_stored", 64'(pmpaddr_o[2]), 64'h55);
    applyStimulus(1'b1, 12'h3A0, 64'h0000_0000_1800_8802);
    checkOutput("w_only_cfg0", 64'(pmpcfg_o[0]), 64'h00);
    applyStimulus(1'b1, 12'h3A0, 64'h0000_0000_1800_8811);
    checkOutput("na4_cfg0", 64'(pmpcfg_o[0]), 64'h00);
    applyStimulus(1'b1, 12'h3B3, 64'h0);
    applyStimulus(1'b0, 12'h3B3, 64'h0);
    checkOutput("napot_view", csr_rdata_o, 64'h1);
    applyStimulus(1'b1, 12'h3B4, 64'hF);
    applyStimulus(1'b0, 12'h3B4, 64'h0);
    checkOutput("off_view", csr_rdata_o, 64'hC);
    checkOutput("off_stored", 64'(pmpaddr_o[4]), 64'hF);

    // Illegal addresses and the upper edge of the pmpaddr window.
    applyStimulus(1'b1, 12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b1, 12'h3F0, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b1, 12'h3EF, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b0, 12'h3AF, 64'd0);

    // Reset while a response is pending.
    applyStimulus(1'b1, 12'h3A2, 64'h0000_0000_0000_000F);
    csr_req_i = 1'b0;
    doReset();

    for (int round = 0; round < 4; round++) begin
      if (round != 0) doReset();
      for (int t = 0; t < 120; t++) begin
        sel = int'($urandom_range(0, 9));
        wd = {$urandom, $urandom};
        if (sel < 4) begin
          addr = 12'h3A0 + 12'($urandom_range(0, 15));
          for (int i = 0; i < 8; i++) if ($urandom_range(0, 11) != 0) wd[i*8+7] = 1'b0;
        end else if (sel < 8) begin
          addr = 12'h3B0 + 12'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 16));
          if ($urandom_range(0, 1) == 0) wd = wd & 64'hFF;
        end else if (sel == 8) begin
          addr = 12'h3F0 + 12'($urandom_range(0, 15));
        end else begin
          addr = 12'($urandom);
        end
        applyStimulus(($urandom_range(0, 2) != 0), addr, wd);
        if ($urandom_range(0, 4) == 0) idleCycle();
      end
    end

    csr_req_i = 1'b0;
    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
